iiravg_sched: RTL and testbench

// Time-shares one recursive-average (IIR, alpha = 2^-LGALPHA) datapath across

---
 rtl/iiravg_sched.sv | 159 +++++++++++++++
 tb/tb_iiravg_sched.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/iiravg_sched.sv
// Round-robin scheduler sharing one recursive-average datapath (alpha = 2^-LGALPHA)
// across NCHAN channels; a clear sequencer loads RESET_VALUE into every average.
//
// state   | meaning
// S_CLEAR | writing RESET_VALUE to avg[cnt_q], one channel per cycle, no grants
// S_RUN   | arbitrating samples and updating averages
module iiravg_sched #(
  parameter int              NCHAN       = 4,
  parameter int              LGNCHAN     = 2,
  parameter int              IW          = 15,
  parameter int              OW          = 16,
  parameter int              LGALPHA     = 4,
  parameter logic [OW-1:0]   RESET_VALUE = '0
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_clear,
  input  logic [NCHAN-1:0]      i_valid,
  input  logic [NCHAN*IW-1:0]   i_data,
  output logic [NCHAN-1:0]      o_ready,
  output logic                  o_busy,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [LGNCHAN-1:0]    o_chan,
  output logic [OW-1:0]         o_data
);

  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [LGNCHAN-1:0]   cnt_q, cnt_d;
  logic [LGNCHAN-1:0]   ptr_q, ptr_d;
  logic                 valid_q, valid_d;
  logic [LGNCHAN-1:0]   chan_q, chan_d;
  logic [OW-1:0]        data_q, data_d;
  logic [OW-1:0]        avg_q [NCHAN];

  logic                 clr_we;
  logic                 run_en;
  logic                 stall;
  logic                 gnt_found;
  logic [LGNCHAN-1:0]   gnt_idx;
  logic                 grant;
  logic [IW-1:0]        sel_data;
  logic [OW-1:0]        sel_avg;
  logic [OW-1:0]        x_w, diff_w, adj_w, new_w;

  // FSM: state register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      S_CLEAR: begin
        if (i_clear) begin
          cnt_d = '0;
        end else if (cnt_q == LGNCHAN'(NCHAN - 1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (i_clear) state_d = S_CLEAR;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // FSM: outputs
  always_comb begin
    clr_we = (state_q == S_CLEAR);
    o_busy = (state_q == S_CLEAR);
    run_en = (state_q == S_RUN) && !i_clear;
  end

  assign stall = valid_q && !i_ready;

  // Round-robin search starting at ptr_q, wrapping at NCHAN
  always_comb begin
    int c;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    c         = 0;
    for (int i = 0; i < NCHAN; i++) begin
      c = int'(ptr_q) + i;
      if (c >= NCHAN) c = c - NCHAN;
      if (!gnt_found && i_valid[c]) begin
        gnt_found = 1'b1;
        gnt_idx   = LGNCHAN'(c);
      end
    end
  end

  assign grant   = run_en && !stall && gnt_found;
  assign o_ready = grant ? (NCHAN'(1) << gnt_idx) : '0;

  // Averages are read combinationally, so a back-to-back grant sees the fresh value
  assign sel_data = i_data[gnt_idx*IW +: IW];
  assign sel_avg  = avg_q[gnt_idx];
  assign x_w      = OW'(sel_data) << (OW - IW);
  assign diff_w   = x_w - sel_avg;
  assign adj_w    = OW'($signed(diff_w) >>> LGALPHA);
  assign new_w    = sel_avg + adj_w;

  always_comb begin
    ptr_d   = ptr_q;
    valid_d = valid_q;
    chan_d  = chan_q;
    data_d  = data_q;
    if (grant) begin
      ptr_d   = (gnt_idx == LGNCHAN'(NCHAN - 1)) ? '0 : gnt_idx + 1'b1;
      valid_d = 1'b1;
      chan_d  = gnt_idx;
      data_d  = new_w;
    end else if (i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      chan_q  <= '0;
      data_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      chan_q  <= chan_d;
      data_q  <= data_d;
    end
  end

  // Average storage carries no reset; CLEAR defines it before any grant
  always_ff @(posedge i_clk) begin
    if (clr_we) begin
      avg_q[cnt_q] <= RESET_VALUE;
    end else if (grant) begin
      avg_q[gnt_idx] <= new_w;
    end
  end

  assign o_valid = valid_q;
  assign o_chan  = chan_q;
  assign o_data  = data_q;

endmodule

// File: tb/tb_iiravg_sched.sv
// Directed and randomized bench for iiravg_sched against a per-channel
// arithmetic model of the averages, grant order and clear timing.
module tb_iiravg_sched;

  localparam int NCHAN = 4;
  localparam int IW    = 15;
  localparam int OW    = 16;
  localparam int LGA   = 4;

  logic                i_clk;
  logic                i_reset;
  logic                i_clear;
  logic [NCHAN-1:0]    i_valid;
  logic [NCHAN*IW-1:0] i_data;
  logic [NCHAN-1:0]    o_ready;
  logic                o_busy;
  logic                o_valid;
  logic                i_ready;
  logic [1:0]          o_chan;
  logic [OW-1:0]       o_data;

  iiravg_sched #(
    .NCHAN(NCHAN), .LGNCHAN(2), .IW(IW), .OW(OW), .LGALPHA(LGA), .RESET_VALUE(16'h0000)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_clear(i_clear), .i_valid(i_valid),
    .i_data(i_data), .o_ready(o_ready), .o_busy(o_busy), .o_valid(o_valid),
    .i_ready(i_ready), .o_chan(o_chan), .o_data(o_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int ncomp = 0;
  int nfail = 0;

  // Reference state
  int          mavg [NCHAN];
  int          mptr;
  int          busy_left;
  logic        mvalid;
  int          mchan;
  int          mdata;
  logic [IW-1:0] din [NCHAN];

  function automatic int wrap(input int v);
    int r;
    r = v & 32'h0000FFFF;
    if (r >= 32768) r = r - 65536;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [NCHAN-1:0] v, input logic rdy, input logic clr);
    int g;
    int x, d, a;
    logic [NCHAN-1:0] er;
    i_valid = v;
    i_ready = rdy;
    i_clear = clr;
    for (int k = 0; k < NCHAN; k++) i_data[k*IW +: IW] = din[k];
    g = -1;
    if (!i_reset && busy_left == 0 && !clr && !(mvalid && !rdy)) begin
      for (int i = 0; i < NCHAN; i++)
        if (g < 0 && v[(mptr + i) % NCHAN]) g = (mptr + i) % NCHAN;
    end
    er = (g >= 0) ? NCHAN'(1 << g) : '0;
    #1;
    if (!i_reset) chk("ready", 32'(o_ready), 32'(er));
    @(posedge i_clk);
    if (i_reset) begin
      busy_left = NCHAN;
      mptr = 0; mvalid = 1'b0; mchan = 0; mdata = 0;
      for (int k = 0; k < NCHAN; k++) mavg[k] = 0;
    end else begin
      if (g >= 0) begin
        x = wrap(int'(din[g]) << (OW - IW));
        d = wrap(x - mavg[g]);
        a = d >>> LGA;
        mavg[g] = wrap(mavg[g] + a);
        mvalid = 1'b1; mchan = g; mdata = mavg[g];
        mptr = (g + 1) % NCHAN;
      end else if (rdy) begin
        mvalid = 1'b0;
      end
      if (clr) begin
        busy_left = NCHAN;
        for (int k = 0; k < NCHAN; k++) mavg[k] = 0;
      end else if (busy_left > 0) begin
        busy_left--;
      end
    end
    #1;
    chk("busy",  32'(o_busy),  32'(busy_left > 0));
    chk("valid", 32'(o_valid), 32'(mvalid));
    chk("chan",  32'(o_chan),  32'(mchan & 3));
    chk("data",  32'(o_data),  32'(mdata & 32'hFFFF));
    @(negedge i_clk);
  endtask

  initial begin
    i_reset = 1'b1; i_clear = 1'b0; i_valid = '0; i_ready = 1'b1; i_data = '0;
    mptr = 0; busy_left = NCHAN; mvalid = 1'b0; mchan = 0; mdata = 0;
    for (int k = 0; k < NCHAN; k++) begin mavg[k] = 0; din[k] = '0; end

    // reset, then ch2 request through the clear window
    cyc(4'b0000, 1'b1, 1'b0);
    cyc(4'b0100, 1'b1, 1'b0);
    i_reset = 1'b0;
    din[2] = 15'($urandom);
    for (int i = 0; i < 5; i++) cyc(4'b0100, 1'b1, 1'b0);
    chk("t1_chan_after_clear", 32'(o_chan), 32'd2);

    // ch0 converging toward 16'h2000
    din[0] = 15'h1000;
    cyc(4'b0001, 1'b1, 1'b0); chk("t2_first",  32'(o_data), 32'h0200);
    cyc(4'b0001, 1'b1, 1'b0); chk("t2_second", 32'(o_data), 32'h03E0);
    cyc(4'b0001, 1'b1, 1'b0); chk("t2_third",  32'(o_data), 32'h05A2);
    for (int i = 0; i < 4; i++) cyc(4'b0001, 1'b1, 1'b0);

    // all channels requesting
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < NCHAN; k++) din[k] = 15'($urandom);
      cyc(4'b1111, 1'b1, 1'b0);
    end

    // downstream stall
    for (int i = 0; i < 5; i++) cyc(4'b1111, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(4'b1111, 1'b1, 1'b0);

    // clear mid-stream, and again two cycles into CLEAR
    cyc(4'b1111, 1'b1, 1'b1);
    cyc(4'b1111, 1'b1, 1'b0);
    cyc(4'b1111, 1'b1, 1'b0);
    cyc(4'b1111, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cyc(4'b1111, 1'b1, 1'b0);
    din[0] = 15'h1000;
    cyc(4'b0001, 1'b1, 1'b0); chk("t6_after_clear", 32'(o_data), 32'h0200);

    // negative input from a zero average
    din[1] = 15'h7000;
    cyc(4'b0010, 1'b1, 1'b0); chk("t5_negative", 32'(o_data), 32'hFE00);
    chk("t5_chan", 32'(o_chan), 32'd1);

    // reset in mid-run behaves like power-up reset
    i_reset = 1'b1;
    cyc(4'b1111, 1'b1, 1'b0);
    i_reset = 1'b0;
    for (int i = 0; i < 6; i++) cyc(4'b0100, 1'b1, 1'b0);

    // randomized traffic
    for (int n = 0; n < 500; n++) begin
      for (int k = 0; k < NCHAN; k++) din[k] = 15'($urandom);
      i_reset = ($urandom_range(0, 199) == 0);
      cyc(4'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0));
    end
    i_reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
